// File: rtl/ex_divider.sv
// Multi-cycle 32-bit integer divider for the EX stage (DIV/DIVU/REM/REMU).
// Restoring radix-2 over 32 cycles; divide-by-zero and signed overflow bypass the loop.
`timescale 1ns/1ps
module ex_divider (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  FUNCT3_IN,
  input  logic [31:0] OUT1_IN,
  input  logic [31:0] OUT2_IN,
  output logic [31:0] RESULT,
  output logic        DONE,
  output logic        BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sel_rem_q, sel_rem_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [31:0] quo_q, quo_d;   // dividend bits shift out the top, quotient bits shift in
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  logic        accept;
  logic        is_signed_in;
  logic        div_zero;
  logic        sig_ovf;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] quo_step;
  logic [31:0] rem_step;
  logic [31:0] quo_fin;
  logic [31:0] rem_fin;

  assign accept       = (state_q == IDLE) && START && FUNCT3_IN[2];
  assign is_signed_in = ~FUNCT3_IN[0];
  assign div_zero     = (OUT2_IN == 32'h0);
  assign sig_ovf      = is_signed_in && (OUT1_IN == 32'h8000_0000) && (OUT2_IN == 32'hFFFF_FFFF);
  assign mag_a        = (is_signed_in && OUT1_IN[31]) ? (32'h0 - OUT1_IN) : OUT1_IN;
  assign mag_b        = (is_signed_in && OUT2_IN[31]) ? (32'h0 - OUT2_IN) : OUT2_IN;

  // One restoring step: shift next dividend bit into the partial remainder and try to subtract.
  assign shifted  = {rem_q, quo_q[31]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign q_bit    = ~diff[32];
  assign rem_step = q_bit ? diff[31:0] : {rem_q[30:0], quo_q[31]};
  assign quo_step = {quo_q[30:0], q_bit};
  assign quo_fin  = (sign_a_q ^ sign_b_q) ? (32'h0 - quo_step) : quo_step;
  assign rem_fin  = sign_a_q ? (32'h0 - rem_step) : rem_step;

  assign BUSYWAIT = ~RESET & (accept | (state_q == CALC));
  assign RESULT   = result_q;
  assign DONE     = done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_rem_d = sel_rem_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_rem_d = FUNCT3_IN[1];
          sign_a_d  = is_signed_in & OUT1_IN[31];
          sign_b_d  = is_signed_in & OUT2_IN[31];
          quo_d     = mag_a;
          dvs_d     = mag_b;
          rem_d     = 32'h0;
          cnt_d     = 6'd0;
          if (div_zero) begin
            state_d  = FINISH;
            done_d   = 1'b1;
            result_d = FUNCT3_IN[1] ? OUT1_IN : 32'hFFFF_FFFF;
          end else if (sig_ovf) begin
            state_d  = FINISH;
            done_d   = 1'b1;
            result_d = FUNCT3_IN[1] ? 32'h0 : 32'h8000_0000;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d  = FINISH;
          done_d   = 1'b1;
          cnt_d    = 6'd0;
          result_d = sel_rem_q ? rem_fin : quo_fin;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      sel_rem_q <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      quo_q     <= 32'h0;
      rem_q     <= 32'h0;
      dvs_q     <= 32'h0;
      result_q  <= 32'h0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_rem_q <= sel_rem_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_ex_divider.sv
// Self-checking bench for ex_divider: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_ex_divider;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [2:0]  FUNCT3_IN;
  logic [31:0] OUT1_IN;
  logic [31:0] OUT2_IN;
  logic [31:0] RESULT;
  logic        DONE;
  logic        BUSYWAIT;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_result;

  ex_divider dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3_IN(FUNCT3_IN),
    .OUT1_IN(OUT1_IN), .OUT2_IN(OUT2_IN), .RESULT(RESULT), .DONE(DONE), .BUSYWAIT(BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'h0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : 32'h8000_0000;
      sa = a;
      sb = b;
      return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return f3[1] ? (a % b) : (a / b);
  endfunction

  function automatic int exp_cycles(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] exp_res, got;
    int exp_n, busy, done_at;
    bit held_ok;
    exp_res = model(f3, a, b);
    exp_n   = exp_cycles(f3, a, b);
    busy = 0; done_at = -1; held_ok = 1; got = 32'h0;
    @(negedge CLK);
    START = 1'b1; FUNCT3_IN = f3; OUT1_IN = a; OUT2_IN = b;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (BUSYWAIT) busy++;
      if (DONE) begin done_at = c; got = RESULT; break; end
      if (RESULT !== last_result) held_ok = 0;
      @(negedge CLK);
      if (c == 0) begin
        START = 1'b0; OUT1_IN = $urandom; OUT2_IN = $urandom; FUNCT3_IN = 3'($urandom);
      end
    end
    n_cmp++;
    if (done_at != exp_n) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", name, done_at, exp_n); end
    n_cmp++;
    if (busy != exp_n) begin n_bad++; $display("FAIL %s busywait cycles: got %0d want %0d", name, busy, exp_n); end
    n_cmp++;
    if (got !== exp_res) begin n_bad++; $display("FAIL %s result: got %h want %h (f3=%b a=%h b=%h)", name, got, exp_res, f3, a, b); end
    n_cmp++;
    if (!held_ok) begin n_bad++; $display("FAIL %s result hold: RESULT changed before DONE, want %h", name, last_result); end
    @(negedge CLK); #1;
    n_cmp++;
    if (DONE !== 1'b0 || BUSYWAIT !== 1'b0) begin
      n_bad++; $display("FAIL %s after done: DONE=%b BUSYWAIT=%b want 0 0", name, DONE, BUSYWAIT);
    end
    last_result = exp_res;
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b1; FUNCT3_IN = 3'b100; OUT1_IN = 32'd100; OUT2_IN = 32'd7;
    repeat (3) @(negedge CLK);
    #1;
    n_cmp++;
    if (RESULT !== 32'h0 || DONE !== 1'b0 || BUSYWAIT !== 1'b0) begin
      n_bad++; $display("FAIL reset_state: RESULT=%h DONE=%b BUSYWAIT=%b want 0 0 0", RESULT, DONE, BUSYWAIT);
    end
    @(negedge CLK);
    RESET = 1'b0; START = 1'b0;
    #1;
    n_cmp++;
    if (BUSYWAIT !== 1'b0) begin n_bad++; $display("FAIL reset_priority: BUSYWAIT=%b want 0", BUSYWAIT); end
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK); #1;
      if (DONE) begin n_cmp++; n_bad++; $display("FAIL reset_priority done: DONE=1 at cycle %0d want 0", c); break; end
    end
    last_result = 32'h0;
  endtask

  task automatic test_directed();
    run_op(3'b101, 32'd100, 32'd7, "divu_100_7");
    run_op(3'b111, 32'd100, 32'd7, "remu_100_7");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_op(3'b100, 32'd5, 32'd0, "div_5_0");
    run_op(3'b110, 32'd5, 32'd0, "rem_5_0");
    run_op(3'b101, 32'hDEAD_BEEF, 32'd0, "divu_x_0");
    run_op(3'b111, 32'hDEAD_BEEF, 32'd0, "remu_x_0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
    run_op(3'b100, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    run_op(3'b110, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");
    run_op(3'b101, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
  endtask

  task automatic test_ignore();
    bit bad;
    bad = 0;
    @(negedge CLK);
    START = 1'b1; FUNCT3_IN = 3'($urandom_range(0, 3)); OUT1_IN = 32'd50; OUT2_IN = 32'd5;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (BUSYWAIT || DONE) bad = 1;
      @(negedge CLK);
    end
    START = 1'b0;
    n_cmp++;
    if (bad) begin n_bad++; $display("FAIL ignore_non_div: BUSYWAIT or DONE asserted, want both 0"); end
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = 32'h0 - $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op(f3, a, b, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    int dones, first_at, second_at;
    logic [31:0] r1, r2;
    bit finish_busy;
    dones = 0; first_at = -1; second_at = -1; r1 = 32'h0; r2 = 32'h0; finish_busy = 0;
    @(negedge CLK);
    START = 1'b1; FUNCT3_IN = 3'b101; OUT1_IN = 32'd1000; OUT2_IN = 32'd7;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (DONE) begin
        dones++;
        if (dones == 1) begin
          first_at = c; r1 = RESULT; finish_busy = BUSYWAIT;
          FUNCT3_IN = 3'b101; OUT1_IN = 32'd9; OUT2_IN = 32'd3;
        end else if (dones == 2) begin
          second_at = c; r2 = RESULT; START = 1'b0;
        end
      end
      @(negedge CLK);
    end
    START = 1'b0;
    n_cmp++;
    if (dones != 2) begin n_bad++; $display("FAIL b2b done count: got %0d want 2", dones); end
    n_cmp++;
    if (r1 !== 32'd142) begin n_bad++; $display("FAIL b2b first result: got %h want %h", r1, 32'd142); end
    n_cmp++;
    if (r2 !== 32'd3) begin n_bad++; $display("FAIL b2b second result: got %h want %h", r2, 32'd3); end
    n_cmp++;
    if (first_at != 33 || second_at != 67) begin
      n_bad++; $display("FAIL b2b timing: done at %0d,%0d want 33,67", first_at, second_at);
    end
    n_cmp++;
    if (finish_busy !== 1'b0) begin n_bad++; $display("FAIL b2b finish busywait: got %b want 0", finish_busy); end
    last_result = 32'd3;
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    saw_done = 0;
    @(negedge CLK);
    START = 1'b1; FUNCT3_IN = 3'b100; OUT1_IN = 32'd12345; OUT2_IN = 32'd11;
    @(negedge CLK);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    #1;
    n_cmp++;
    if (BUSYWAIT !== 1'b1) begin n_bad++; $display("FAIL abort pre-reset busywait: got %b want 1", BUSYWAIT); end
    RESET = 1'b1;
    #1;
    n_cmp++;
    if (BUSYWAIT !== 1'b0) begin n_bad++; $display("FAIL abort busywait during reset: got %b want 0", BUSYWAIT); end
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    n_cmp++;
    if (BUSYWAIT !== 1'b0 || RESULT !== 32'h0 || DONE !== 1'b0) begin
      n_bad++; $display("FAIL abort state: BUSYWAIT=%b RESULT=%h DONE=%b want 0 0 0", BUSYWAIT, RESULT, DONE);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK); #1;
      if (DONE) saw_done = 1;
    end
    n_cmp++;
    if (saw_done) begin n_bad++; $display("FAIL abort done: DONE pulsed after reset, want none"); end
    last_result = 32'h0;
  endtask

  initial begin
    last_result = 32'h0;
    test_reset();
    test_directed();
    test_ignore();
    test_back_to_back();
    test_reset_abort();
    test_random();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
